// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer with prescaler, auto-reload and sticky expiry interrupt
module mmio_timer #(
    parameter logic [31:0] BASE = 32'hFFFF0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic [31:0] memreaddata,
    output logic        irq
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic        auto_rl, ie, exp_flag;
    logic [7:0]  presc, pre;
    logic [31:0] load, count, ctrl;
    logic        sel, wr_ctrl, wr_load, clr, tick, expire, exp_n, ie_n, unused_ok;
    logic [1:0]  off;

    assign sel       = memaddr[31:4] == BASE[31:4];
    assign off       = memaddr[3:2];
    assign wr_ctrl   = memwrite && sel && off == 2'd0;
    assign wr_load   = memwrite && sel && off == 2'd1;
    assign clr       = memwrite && sel && off == 2'd3 && memwritedata[0];
    assign tick      = state == RUN && pre == presc;
    assign expire    = tick && count == 32'd0;
    assign exp_n     = expire || (exp_flag && !clr);
    assign ie_n      = wr_ctrl ? memwritedata[2] : ie;
    assign ctrl      = {16'd0, presc, 5'd0, ie, auto_rl, state == RUN};
    assign unused_ok = &memaddr[1:0];

    // Read mux: selected register, zero when the window is not addressed
    always_comb
        memreaddata = !sel        ? 32'd0 :
                      off == 2'd0 ? ctrl  :
                      off == 2'd1 ? load  :
                      off == 2'd2 ? count : {31'd0, exp_flag};

    // Timer FSM: prescaling, counting, reloads and register writes (CTRL write wins over expiry)
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            presc    <= 8'd0;
            pre      <= 8'd0;
            load     <= 32'd0;
            count    <= 32'd0;
            exp_flag <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (state == RUN) begin
                pre <= tick ? 8'd0 : pre + 8'd1;
                if (tick)
                    count <= count != 32'd0 ? count - 32'd1 : auto_rl ? load : count;
                if (expire && !auto_rl)
                    state <= IDLE;
            end
            if (wr_load) begin
                load <= memwritedata;
                if (state == IDLE)
                    count <= memwritedata;
            end
            if (wr_ctrl) begin
                auto_rl <= memwritedata[1];
                ie      <= memwritedata[2];
                presc   <= memwritedata[15:8];
                if (!memwritedata[0]) begin
                    state <= IDLE;
                    count <= count;
                end else if (state == IDLE) begin
                    state <= RUN;
                    count <= load;
                    pre   <= 8'd0;
                end else begin
                    state <= RUN;
                end
            end
            exp_flag <= exp_n;
            irq      <= exp_n && ie_n;
        end
    end
endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter BASE, default 32'hFFFF0000, meaning the 16-byte-aligned base address of the register window.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port memwrite  input  1  the CPU store strobe; a write occurs at the clk edge while it is high.
REQ-005 SHALL have port memaddr  input  32  the CPU data address; bits [1:0] are ignored.
REQ-006 SHALL have port memwritedata  input  32  the CPU store data.
REQ-007 SHALL have port memreaddata  output  32  combinational read data, valid in the same cycle as memaddr.
REQ-008 SHALL have port irq  output  1  registered interrupt request.

Function
REQ-009 SHALL assert select when memaddr[31:4] == BASE[31:4]; the register offset is memaddr[3:2].
REQ-010 SHALL decode register map: 0 CTRL (RW), 1 LOAD (RW), 2 COUNT (RO), 3 STATUS (R/W1C).
REQ-011 SHALL define CTRL fields: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bits[15:8] PRESC; all other bits read 0.
REQ-012 SHALL define STATUS bit0 EXP (sticky expiry flag); all other bits read 0.
REQ-013 SHALL drive memreaddata with the selected register when select is high, and 32'h0 otherwise, independent of memwrite.
REQ-014 SHALL ignore memwrite when select is low, and ignore writes to COUNT.
REQ-015 SHALL implement two states: IDLE (EN=0) and RUN (EN=1).
REQ-016 IDLE->RUN on a CTRL write with EN=1: COUNT<=LOAD and prescale counter<=0 at the same edge.
REQ-017 A CTRL write with EN=1 while already in RUN SHALL update AUTO/IE/PRESC only, without reloading COUNT.
REQ-018 RUN->IDLE on a CTRL write with EN=0; COUNT SHALL hold its value.
REQ-019 In RUN the prescale counter SHALL increment each cycle; when it equals PRESC it wraps to 0 and generates a tick, giving a tick every PRESC+1 cycles (PRESC=0 gives a tick every cycle).
REQ-020 On a tick with COUNT != 0, COUNT SHALL decrement by 1.
REQ-021 On a tick with COUNT == 0, EXP<=1, then:
- if AUTO=1, COUNT<=LOAD and the state stays RUN;
- if AUTO=0, EN<=0 and the state goes to IDLE.
REQ-022 A LOAD write in IDLE SHALL also set COUNT<=new value; a LOAD write in RUN SHALL affect only the next reload.
REQ-023 A STATUS write with bit0=1 SHALL clear EXP; writing 0 has no effect.
REQ-024 When a STATUS clear and an expiry occur in the same cycle, EXP SHALL be 1 (set wins).
REQ-025 When a CTRL write and an expiry occur in the same cycle, the CTRL write SHALL win for EN, AUTO, IE and PRESC; the expiry still sets EXP.
REQ-026 irq SHALL be registered as EXP & IE, using next-state values, so irq rises at the same edge EXP sets.
REQ-027 COUNT SHALL be 32-bit unsigned and SHALL never wrap below 0 (REQ-021 governs the zero case).

Reset
REQ-028 On reset, CTRL, LOAD, COUNT, the prescale counter, EXP and irq SHALL all be 0 and the state SHALL be IDLE.
REQ-029 Reset asserted mid-count SHALL abort the count at the next edge, with no EXP or irq set.

Verification
REQ-030 Read-back: reset, write LOAD=32'h0000_0010 at BASE+4 -> read BASE+4 = 32'h10, BASE+8 = 32'h10, BASE+0 = 0; read address 32'h0000_0040 -> memreaddata = 0.
REQ-031 One-shot: LOAD=3, CTRL=32'h5 (EN, IE, PRESC=0) -> COUNT reads 3,2,1,0 on successive cycles; EXP=1 and irq=1 at the fourth edge after the CTRL write; CTRL then reads 32'h4.
REQ-032 Prescale and auto-reload: LOAD=1, CTRL=32'h0000_0303 (PRESC=3) -> COUNT changes every 4 cycles, reloads to 1 after expiry, EXP stays 1, irq stays 0.
REQ-033 Clear race: write STATUS=1 in the exact expiry cycle -> EXP remains 1; write STATUS=1 one cycle later -> EXP=0 and irq=0 on the following cycle.
REQ-034 Reset mid-operation: LOAD=100, enable, reset after 10 cycles -> all registers read 0 and irq=0; no further COUNT change without a new CTRL write.
